// File: rtl/scan_pkg.sv
// scan_pkg: shared constants and helpers for the 32x16 LED-matrix
// scan interface, used by both the game-core driver and the capture side.
package scan_pkg;

  localparam int ROWS  = 32;
  localparam int COLS  = 16;
  localparam int ROW_W = $clog2(ROWS);

  typedef enum logic {
    HUNT,
    CAPTURE
  } scan_state_e;

  typedef struct packed {
    logic [ROW_W-1:0] idx;
    logic             ok;
  } row_dec_t;

  // MSB of com is row 0; ok is low for all-zero or multi-hot strobes
  function automatic row_dec_t onehot_to_row(logic [ROWS-1:0] com);
    row_dec_t    r;
    int unsigned n;
    r = '0;
    n = 0;
    for (int i = 0; i < ROWS; i++) begin
      if (com[i]) begin
        n++;
        r.idx = ROW_W'(ROWS - 1 - i);
      end
    end
    r.ok = (n == 1);
    return r;
  endfunction

endpackage

// File: rtl/scan_row_decoder.sv
// scan_row_decoder: one-hot row strobe to row index plus validity flag.
// Purely combinational.
module scan_row_decoder
  import scan_pkg::*;
(
  input  logic [ROWS-1:0]  com_i,
  output logic [ROW_W-1:0] row_o,
  output logic             ok_o
);

  row_dec_t dec;

  assign dec   = onehot_to_row(com_i);
  assign row_o = dec.idx;
  assign ok_o  = dec.ok;

endmodule

// File: rtl/scan_frame_capture.sv
// scan_frame_capture: rebuilds scan frames into a double-buffered store,
// with a registered read port and protocol-violation counting.
module scan_frame_capture #(
  parameter int ROWS   = scan_pkg::ROWS,
  parameter int COLS   = scan_pkg::COLS,
  parameter int FCNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ROWS-1:0]   com,
  input  logic [COLS-1:0]   column,
  input  logic [4:0]        rd_row,
  output logic [COLS-1:0]   rd_data,
  output logic              frame_done,
  output logic [FCNT_W-1:0] frame_cnt,
  output logic              sync,
  output logic [7:0]        err_cnt
);
  import scan_pkg::*;

  logic [ROWS-1:0]   com_q;
  logic [COLS-1:0]   col_q;
  logic              vld_q;
  logic [ROW_W-1:0]  row;
  logic              ok;

  scan_state_e       state_q, state_d;
  logic [ROW_W-1:0]  exp_q, exp_d;
  logic              bank_sel_q, bank_sel_d;
  logic              wr_en;
  logic              done_d;
  logic              bad;

  logic [1:0][ROWS-1:0][COLS-1:0] bank_q;
  logic [COLS-1:0]   rd_q;
  logic              done_q;
  logic [FCNT_W-1:0] fcnt_q;
  logic [7:0]        err_q;

  scan_row_decoder u_dec (
    .com_i (com_q),
    .row_o (row),
    .ok_o  (ok)
  );

  // vld_q keeps the cleared s1 stage from counting as a bad strobe
  always_comb begin
    state_d    = state_q;
    exp_d      = exp_q;
    bank_sel_d = bank_sel_q;
    wr_en      = 1'b0;
    done_d     = 1'b0;
    bad        = 1'b0;
    if (vld_q) begin
      unique case (state_q)
        HUNT: begin
          if (!ok) begin
            bad = 1'b1;
          end else if (row == '0) begin
            wr_en   = 1'b1;
            exp_d   = ROW_W'(1);
            state_d = CAPTURE;
          end
        end
        CAPTURE: begin
          if (ok && row == exp_q) begin
            wr_en = 1'b1;
            if (row == ROW_W'(ROWS - 1)) begin
              bank_sel_d = ~bank_sel_q;
              done_d     = 1'b1;
              state_d    = HUNT;
            end else begin
              exp_d = exp_q + 1'b1;
            end
          end else if (ok && row == exp_q - 1'b1) begin
            wr_en = 1'b1;
          end else begin
            bad     = 1'b1;
            state_d = HUNT;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      com_q      <= '0;
      col_q      <= '0;
      vld_q      <= 1'b0;
      state_q    <= HUNT;
      exp_q      <= '0;
      bank_sel_q <= 1'b0;
      done_q     <= 1'b0;
      fcnt_q     <= '0;
      err_q      <= '0;
    end else begin
      com_q      <= com;
      col_q      <= column;
      vld_q      <= 1'b1;
      state_q    <= state_d;
      exp_q      <= exp_d;
      bank_sel_q <= bank_sel_d;
      done_q     <= done_d;
      if (done_d)
        fcnt_q <= fcnt_q + 1'b1;
      if (bad && err_q != 8'hFF)
        err_q <= err_q + 1'b1;
    end
  end

  // only the back bank is written, so display reads never tear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bank_q <= '0;
      rd_q   <= '0;
    end else begin
      if (wr_en)
        bank_q[~bank_sel_q][row] <= col_q;
      rd_q <= bank_q[bank_sel_q][rd_row];
    end
  end

  assign rd_data    = rd_q;
  assign frame_done = done_q;
  assign frame_cnt  = fcnt_q;
  assign sync       = (state_q == CAPTURE);
  assign err_cnt    = err_q;

endmodule

// File: tb/tb_scan_frame_capture.sv
// tb_scan_frame_capture: randomized scan streams checked against a
// frame-level reference model of the capture rules.
module tb_scan_frame_capture;

  localparam int R = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] com = '0;
  logic [15:0] column = '0;
  logic [4:0]  rd_row = '0;
  logic [15:0] rd_data;
  logic        frame_done;
  logic [15:0] frame_cnt;
  logic        sync;
  logic [7:0]  err_cnt;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  scan_frame_capture dut (
    .clk        (clk),
    .rst        (rst),
    .com        (com),
    .column     (column),
    .rd_row     (rd_row),
    .rd_data    (rd_data),
    .frame_done (frame_done),
    .frame_cnt  (frame_cnt),
    .sync       (sync),
    .err_cnt    (err_cnt)
  );

  logic [15:0] m_back [R];
  logic [15:0] m_disp [R];
  bit          m_lock;
  int          m_exp;
  logic [7:0]  m_err;
  logic [15:0] m_cnt;
  logic [15:0] m_rd;
  logic        m_done;
  logic [31:0] p_com;
  logic [15:0] p_col;
  bit          p_v;

  logic [15:0] pat [3][R];

  function automatic logic [31:0] oh(int r);
    logic [31:0] top;
    top = 32'h8000_0000;
    return top >> r;
  endfunction

  task automatic m_reset();
    foreach (m_back[i]) m_back[i] = '0;
    foreach (m_disp[i]) m_disp[i] = '0;
    m_lock = 0; m_exp = 0; m_err = '0; m_cnt = '0;
    m_rd = '0; m_done = 1'b0;
    p_com = '0; p_col = '0; p_v = 0;
  endtask

  task automatic m_proc(logic [31:0] c, logic [15:0] d);
    bit ok;
    int row;
    ok  = ($countones(c) == 1);
    row = -1;
    if (ok) begin
      row = 0;
      while (oh(row) != c) row++;
    end
    if (!m_lock) begin
      if (!ok) begin
        if (m_err != 8'hFF) m_err++;
      end else if (row == 0) begin
        m_back[0] = d; m_exp = 1; m_lock = 1;
      end
    end else if (ok && row == m_exp) begin
      m_back[row] = d;
      if (row == R - 1) begin
        m_disp = m_back; m_lock = 0; m_done = 1'b1; m_cnt++;
      end else begin
        m_exp++;
      end
    end else if (ok && row == m_exp - 1) begin
      m_back[row] = d;
    end else begin
      if (m_err != 8'hFF) m_err++;
      m_lock = 0;
    end
  endtask

  task automatic drive(logic [31:0] c, logic [15:0] d, logic [4:0] r);
    com = c; column = d; rd_row = r;
    @(posedge clk);
    if (!rst) begin
      m_reset();
    end else begin
      m_rd   = m_disp[r];
      m_done = 1'b0;
      if (p_v) m_proc(p_com, p_col);
      p_com = c; p_col = d; p_v = 1;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    m_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_chk++;
    if ({rd_data, frame_done, frame_cnt, sync, err_cnt} !== 42'd0)
      $display("FAIL reset_vals: got %h want 0",
               {rd_data, frame_done, frame_cnt, sync, err_cnt});
    else n_pass++;
    rst = 1'b1;
  endtask

  task automatic test_single_frame();
    for (int r = 0; r < R; r++) begin
      drive(oh(r), 16'(r), 5'($urandom));
      n_chk++;
      if ({rd_data, frame_done, sync, err_cnt, frame_cnt} !==
          {m_rd, m_done, m_lock, m_err, m_cnt})
        $display("FAIL single_cyc r=%0d: got %h want %h", r,
                 {rd_data, frame_done, sync, err_cnt, frame_cnt},
                 {m_rd, m_done, m_lock, m_err, m_cnt});
      else n_pass++;
    end
    n_chk++;
    if (sync !== 1'b1)
      $display("FAIL single_sync_hi: got %b want 1", sync);
    else n_pass++;
    drive(oh(31), 16'h0, 5'd0);
    n_chk++;
    if ({frame_done, frame_cnt, sync} !== {1'b1, 16'd1, 1'b0})
      $display("FAIL single_done: got %h want %h",
               {frame_done, frame_cnt, sync}, {1'b1, 16'd1, 1'b0});
    else n_pass++;
    drive(oh(31), 16'h0, 5'd0);
    n_chk++;
    if (frame_done !== 1'b0)
      $display("FAIL single_pulse: got %b want 0", frame_done);
    else n_pass++;
    for (int r = 0; r < R; r++) begin
      drive(oh(31), 16'h0, 5'(r));
      n_chk++;
      if (rd_data !== 16'(r))
        $display("FAIL single_read r=%0d: got %h want %h", r, rd_data, 16'(r));
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  e0;
    logic [15:0] c0;
    logic [15:0] want;
    int dones, at_row0;
    e0 = m_err; c0 = m_cnt; dones = 0; at_row0 = 0;
    foreach (pat[f, r]) pat[f][r] = 16'($urandom);
    for (int f = 0; f < 4; f++) begin
      for (int r = 0; r < R; r++) begin
        if (f == 3 && r > 1) break;
        drive(f < 3 ? oh(r) : oh(31), f < 3 ? pat[f][r] : 16'h0,
              r < 2 ? 5'd7 : 5'($urandom));
        n_chk++;
        if ({rd_data, frame_done, sync, err_cnt, frame_cnt} !==
            {m_rd, m_done, m_lock, m_err, m_cnt})
          $display("FAIL b2b_cyc f=%0d r=%0d: got %h want %h", f, r,
                   {rd_data, frame_done, sync, err_cnt, frame_cnt},
                   {m_rd, m_done, m_lock, m_err, m_cnt});
        else n_pass++;
        if (frame_done) begin
          dones++;
          if (r == 0) at_row0++;
        end
        if (f > 0 && r == 0) begin
          want = (f >= 2) ? pat[f-2][7] : 16'd7;
          n_chk++;
          if (rd_data !== want)
            $display("FAIL b2b_swap_old f=%0d: got %h want %h", f, rd_data, want);
          else n_pass++;
        end
        if (f > 0 && r == 1) begin
          n_chk++;
          if (rd_data !== pat[f-1][7])
            $display("FAIL b2b_swap_new f=%0d: got %h want %h", f,
                     rd_data, pat[f-1][7]);
          else n_pass++;
        end
      end
    end
    n_chk++;
    if ({frame_cnt, err_cnt} !== {16'(c0 + 3), e0})
      $display("FAIL b2b_counts: got %h want %h",
               {frame_cnt, err_cnt}, {16'(c0 + 3), e0});
    else n_pass++;
    n_chk++;
    if (dones != 3 || at_row0 != 3)
      $display("FAIL b2b_gapless: got %0d/%0d want 3/3", dones, at_row0);
    else n_pass++;
  endtask

  task automatic test_errors();
    logic [7:0]  e0;
    logic [15:0] c0;
    logic [31:0] c;
    int dones;
    e0 = m_err; c0 = m_cnt; dones = 0;
    for (int f = 0; f < 2; f++) begin
      for (int r = 0; r < R; r++) begin
        c = oh(r);
        if (f == 0 && r == 10) c = 32'h0;
        if (f == 1 && r == 6) c = 32'h3;
        drive(c, 16'($urandom), 5'(r));
        n_chk++;
        if ({rd_data, frame_done, sync, err_cnt, frame_cnt} !==
            {m_rd, m_done, m_lock, m_err, m_cnt})
          $display("FAIL err_cyc f=%0d r=%0d: got %h want %h", f, r,
                   {rd_data, frame_done, sync, err_cnt, frame_cnt},
                   {m_rd, m_done, m_lock, m_err, m_cnt});
        else n_pass++;
        if (frame_done) dones++;
        if (r % 8 == 3) begin
          n_chk++;
          if (rd_data !== pat[2][r])
            $display("FAIL err_disp r=%0d: got %h want %h", r, rd_data, pat[2][r]);
          else n_pass++;
        end
        if (f == 1 && r == 1) begin
          n_chk++;
          if (sync !== 1'b1)
            $display("FAIL err_relock: got %b want 1", sync);
          else n_pass++;
        end
      end
    end
    n_chk++;
    if ({err_cnt, frame_cnt} !== {8'(e0 + 2), c0} || dones != 0)
      $display("FAIL err_counts: got %h dones=%0d want %h dones=0",
               {err_cnt, frame_cnt}, dones, {8'(e0 + 2), c0});
    else n_pass++;
  endtask

  task automatic test_skip_hold();
    logic [7:0]  e0;
    logic [15:0] c0;
    int q[$];
    e0 = m_err; c0 = m_cnt;
    for (int r = 0; r < R; r++) if (r != 5) q.push_back(r);
    for (int r = 0; r < R; r++) begin
      q.push_back(r);
      if (r == 7) begin q.push_back(7); q.push_back(7); end
    end
    q.push_back(31); q.push_back(31);
    foreach (q[i]) begin
      drive(oh(q[i]), 16'($urandom), 5'($urandom));
      n_chk++;
      if ({rd_data, frame_done, sync, err_cnt, frame_cnt} !==
          {m_rd, m_done, m_lock, m_err, m_cnt})
        $display("FAIL skip_cyc i=%0d: got %h want %h", i,
                 {rd_data, frame_done, sync, err_cnt, frame_cnt},
                 {m_rd, m_done, m_lock, m_err, m_cnt});
      else n_pass++;
      if (i >= 6 && i <= 31) begin
        n_chk++;
        if (sync !== 1'b0)
          $display("FAIL skip_unlock i=%0d: got %b want 0", i, sync);
        else n_pass++;
      end
    end
    n_chk++;
    if ({err_cnt, frame_cnt} !== {8'(e0 + 1), 16'(c0 + 1)})
      $display("FAIL skip_counts: got %h want %h",
               {err_cnt, frame_cnt}, {8'(e0 + 1), 16'(c0 + 1)});
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    for (int r = 0; r <= 20; r++) begin
      drive(oh(r), 16'($urandom), 5'($urandom));
      n_chk++;
      if ({rd_data, frame_done, sync, err_cnt, frame_cnt} !==
          {m_rd, m_done, m_lock, m_err, m_cnt})
        $display("FAIL rmid_cyc r=%0d: got %h want %h", r,
                 {rd_data, frame_done, sync, err_cnt, frame_cnt},
                 {m_rd, m_done, m_lock, m_err, m_cnt});
      else n_pass++;
    end
    rst = 1'b0;
    m_reset();
    #1;
    n_chk++;
    if ({rd_data, frame_done, frame_cnt, sync, err_cnt} !== 42'd0)
      $display("FAIL rmid_async: got %h want 0",
               {rd_data, frame_done, frame_cnt, sync, err_cnt});
    else n_pass++;
    drive(oh(21), 16'($urandom), 5'd3);
    n_chk++;
    if ({rd_data, frame_done, frame_cnt, sync, err_cnt} !== 42'd0)
      $display("FAIL rmid_hold: got %h want 0",
               {rd_data, frame_done, frame_cnt, sync, err_cnt});
    else n_pass++;
    rst = 1'b1;
    for (int r = 22; r < R; r++) begin
      drive(oh(r), 16'($urandom), 5'(r));
      n_chk++;
      if (rd_data !== 16'h0 || sync !== 1'b0)
        $display("FAIL rmid_rd r=%0d: got %h/%b want 0/0", r, rd_data, sync);
      else n_pass++;
    end
    for (int r = 0; r < R + 2; r++) begin
      drive(r < R ? oh(r) : oh(31), 16'($urandom), 5'($urandom));
      n_chk++;
      if ({rd_data, frame_done, sync, err_cnt, frame_cnt} !==
          {m_rd, m_done, m_lock, m_err, m_cnt})
        $display("FAIL rmid_frame r=%0d: got %h want %h", r,
                 {rd_data, frame_done, sync, err_cnt, frame_cnt},
                 {m_rd, m_done, m_lock, m_err, m_cnt});
      else n_pass++;
    end
    n_chk++;
    if (frame_cnt !== 16'd1)
      $display("FAIL rmid_fcnt: got %0d want 1", frame_cnt);
    else n_pass++;
  endtask

  task automatic test_saturate();
    logic [31:0] c;
    for (int i = 0; i < 300; i++) begin
      c = ($urandom_range(0, 1) == 0) ? 32'h0 : (32'h3 << $urandom_range(0, 30));
      drive(c, 16'($urandom), 5'($urandom));
      n_chk++;
      if ({rd_data, frame_done, sync, err_cnt, frame_cnt} !==
          {m_rd, m_done, m_lock, m_err, m_cnt})
        $display("FAIL sat_cyc i=%0d: got %h want %h", i,
                 {rd_data, frame_done, sync, err_cnt, frame_cnt},
                 {m_rd, m_done, m_lock, m_err, m_cnt});
      else n_pass++;
    end
    n_chk++;
    if (err_cnt !== 8'hFF)
      $display("FAIL sat_final: got %0d want 255", err_cnt);
    else n_pass++;
  endtask

  initial begin
    m_reset();
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_errors();
    test_skip_hold();
    test_reset_mid();
    test_saturate();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
